// File: rtl/lifo_stack.sv
// lifo_stack: operand stack for the multicycle stack processor.
// Push/pop requests are sampled on each rising clk edge. Pop data is
// registered (valid the edge after the pop). full/empty/count come straight
// from the registered stack pointer, so they have no combinational path from
// push/pop. Sticky overflow/underflow flags record rejected operations.
//
// Request semantics: push and pop are level requests with no ready/backpressure.
// A request that the stack cannot honour (push when full, pop when empty) is
// dropped and recorded in the matching sticky flag. The caller is expected to
// consult full/empty before issuing a request.
module lifo_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] top,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    // Storage and stack pointer (sp == count == next free slot).
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           sp;
    logic [AW:0]           sp_m1;

    // Decoded operation for the current edge.
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic                  rd_en;
    logic [AW:0]           sp_next;
    logic                  ovf_set;
    logic                  unf_set;

    assign sp_m1 = sp - ONE;
    assign full  = (sp == FULL_CNT);
    assign empty = (sp == '0);
    assign count = sp;
    // Peek at the current top of stack; an empty stack reads as zero.
    assign top   = empty ? '0 : mem[sp_m1[AW-1:0]];

    // Decode {push, pop} against the current occupancy into write/read/pointer actions.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sp[AW-1:0];
        rd_en   = 1'b0;
        sp_next = sp;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    sp_next = sp + ONE;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    rd_en   = 1'b1;
                    sp_next = sp_m1;
                end else begin
                    unf_set = 1'b1;
                end
            end
            2'b11: begin
                if (!empty) begin
                    // Replace: return the old top and overwrite it in place.
                    // Occupancy is unchanged, so this is legal even when full.
                    rd_en   = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = sp_m1[AW-1:0];
                end else begin
                    // Nothing to pop: the push half still goes through.
                    wr_en   = 1'b1;
                    sp_next = sp + ONE;
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pointer, pop data and sticky flags; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            sp        <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp <= sp_next;
            if (rd_en) begin
                data_out <= mem[sp_m1[AW-1:0]];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end
        end
    end

    // Entry array; contents are not cleared by reset, but reset suppresses writes.
    always_ff @(posedge clk) begin
        if (resetN && wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: table-driven directed vectors for lifo_stack plus hand-written
// multi-cycle sequences (fill to full, overflow, replace while full, drain,
// reset during push).
module tb_lifo_stack;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    // Clock / reset and DUT signals.
    logic          clk;
    logic          resetN;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [DW-1:0] top;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    lifo_stack #(.DATA_WIDTH(DW), .DEPTH(DP), .AW(AW)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .data_out  (data_out),
        .top       (top),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One vector: inputs for an edge and the expected outputs after it.
    typedef struct {
        logic          rst_n;
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic [DW-1:0] top;
        logic [AW:0]   cnt;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic pu, input logic po,
                                input logic [DW-1:0] di, input logic [DW-1:0] dq,
                                input logic [DW-1:0] tp, input logic [AW:0] c,
                                input logic f, input logic e, input logic ov,
                                input logic un);
        vec_t v;
        v.rst_n = r;  v.push = pu; v.pop = po; v.din = di;
        v.dout  = dq; v.top  = tp; v.cnt = c;  v.full = f;
        v.empty = e;  v.ovf  = ov; v.unf = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp_v);
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", n_vec, name, act, exp_v);
        end
    endtask

    // Drive inputs away from the active edge, then sample #1 after it.
    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        resetN  = v.rst_n;
        push    = v.push;
        pop     = v.pop;
        data_in = v.din;
        @(posedge clk);
        #1;
        chk("data_out",  data_out,            v.dout);
        chk("top",       top,                 v.top);
        chk("count",     DW'(count),          DW'(v.cnt));
        chk("full",      DW'(full),           DW'(v.full));
        chk("empty",     DW'(empty),          DW'(v.empty));
        chk("overflow",  DW'(overflow),       DW'(v.ovf));
        chk("underflow", DW'(underflow),      DW'(v.unf));
        n_vec++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        resetN  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;

        //              rst pu po din    dout   top    cnt f  e  ov un
        vecs.push_back(mk(0, 1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 1, 0, 0)); // reset beats push
        vecs.push_back(mk(1, 1, 0, 8'h11, 8'h00, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h22, 8'h00, 8'h22, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h33, 8'h00, 8'h33, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h33, 8'h22, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h22, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h11, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h11, 8'h00, 0, 0, 1, 0, 1)); // pop empty
        vecs.push_back(mk(1, 1, 0, 8'h44, 8'h11, 8'h44, 1, 0, 0, 0, 1)); // push still works
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h44, 8'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h05, 8'h44, 8'h05, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h07, 8'h44, 8'h07, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 8'h0C, 8'h07, 8'h0C, 2, 0, 0, 0, 1)); // replace
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h0C, 8'h05, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h05, 8'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h03, 8'h05, 8'h03, 1, 0, 0, 0, 1)); // ADD pattern
        vecs.push_back(mk(1, 1, 0, 8'h04, 8'h05, 8'h04, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h04, 8'h03, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 8'h00, 8'h03, 8'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h07, 8'h03, 8'h07, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0)); // reset clears flags
        vecs.push_back(mk(1, 1, 1, 8'h66, 8'h00, 8'h66, 1, 0, 0, 0, 1)); // 11 on empty
        vecs.push_back(mk(1, 0, 0, 8'h99, 8'h00, 8'h66, 1, 0, 0, 0, 1)); // idle holds

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
        end

        // Fill to full from a fresh reset.
        apply_vec(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0));
        for (int i = 0; i < DP; i++) begin
            apply_vec(mk(1, 1, 0, DW'(i + 1), 8'h00, DW'(i + 1), (AW+1)'(i + 1),
                         (i == DP - 1), 0, 0, 0));
        end
        // Replace while full: no overflow.
        apply_vec(mk(1, 1, 1, 8'hEE, 8'h10, 8'hEE, 16, 1, 0, 0, 0));
        // Push into a full stack: rejected, overflow set, top unchanged.
        apply_vec(mk(1, 1, 0, 8'h77, 8'h10, 8'hEE, 16, 1, 0, 1, 0));
        // Drain down to 5 entries; each slot k holds k+1 except the replaced top.
        for (int i = 0; i < 11; i++) begin
            apply_vec(mk(1, 0, 1, 8'h00, (i == 0) ? 8'hEE : DW'(16 - i),
                         DW'(15 - i), (AW+1)'(15 - i), 0, 0, 1, 0));
        end
        // Reset with push high: no write, everything cleared.
        apply_vec(mk(0, 1, 0, 8'h99, 8'h00, 8'h00, 0, 0, 1, 0, 0));
        apply_vec(mk(1, 1, 0, 8'h5A, 8'h00, 8'h5A, 1, 0, 0, 0, 0));
        apply_vec(mk(1, 0, 1, 8'h00, 8'h5A, 8'h00, 0, 0, 1, 0, 0));

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
